// File: rtl/dbf_pkg.sv
// -----------------------------------------------------------------------------
// dbf_pkg
// Shared definitions for the N-channel digital beamformer cell:
//   - clog2()          : ceiling log2 for index and tree-depth sizing
//   - calc_pw/calc_sw  : complex product width and adder-tree sum width
//   - sat_hi/sat_lo    : signed saturation limits of the DW-bit beam output
//   - PW, SW           : derived widths for the default configuration
//   - wt_state_t       : weight-bank swap state {ACTIVE, PENDING}
// -----------------------------------------------------------------------------
package dbf_pkg;

    function automatic int clog2(input int value);
        int res;
        int v;
        res = 0;
        v   = value - 1;
        while (v > 0) begin
            res = res + 1;
            v   = v >> 1;
        end
        return res;
    endfunction

    // Product of a DW-bit and a WW-bit signed operand, plus one bit for the
    // sum/difference of two such products.
    function automatic int calc_pw(input int dw, input int ww);
        return dw + ww + 1;
    endfunction

    // Each pairwise adder level grows the word by one bit.
    function automatic int calc_sw(input int dw, input int ww, input int n_ch);
        return calc_pw(dw, ww) + clog2(n_ch);
    endfunction

    function automatic longint sat_hi(input int dw);
        return (longint'(1) <<< (dw - 1)) - 1;
    endfunction

    function automatic longint sat_lo(input int dw);
        return -(longint'(1) <<< (dw - 1));
    endfunction

    localparam int DEF_N_CH = 4;
    localparam int DEF_DW   = 16;
    localparam int DEF_WW   = 16;
    localparam int PW       = calc_pw(DEF_DW, DEF_WW);
    localparam int SW       = calc_sw(DEF_DW, DEF_WW, DEF_N_CH);

    typedef enum logic {
        ACTIVE  = 1'b0,
        PENDING = 1'b1
    } wt_state_t;

endpackage

// File: rtl/dbf_cmult.sv
// -----------------------------------------------------------------------------
// dbf_cmult
// Two-stage pipelined signed complex multiplier (a * w).
//   stage 1: registers the four partial products
//   stage 2: registers p_re = a_re*w_re - a_im*w_im, p_im = a_re*w_im + a_im*w_re
// Ports:
//   clk        in   system clock
//   a_re,a_im  in   DW-bit signed sample
//   w_re,w_im  in   WW-bit signed weight
//   p_re,p_im  out  (DW+WW+1)-bit signed product, two cycles after the inputs
// Pure datapath: validity is tracked by the instantiating module.
// -----------------------------------------------------------------------------
module dbf_cmult
    import dbf_pkg::*;
#(
    parameter int DW = 16,
    parameter int WW = 16
) (
    input  logic                             clk,
    input  logic signed [DW-1:0]             a_re,
    input  logic signed [DW-1:0]             a_im,
    input  logic signed [WW-1:0]             w_re,
    input  logic signed [WW-1:0]             w_im,
    output logic signed [calc_pw(DW,WW)-1:0] p_re,
    output logic signed [calc_pw(DW,WW)-1:0] p_im
);

    localparam int MW     = DW + WW;
    localparam int PROD_W = calc_pw(DW, WW);

    logic signed [MW-1:0] prod_rr;
    logic signed [MW-1:0] prod_ii;
    logic signed [MW-1:0] prod_ri;
    logic signed [MW-1:0] prod_ir;

    // NOTE: registers are updated with non-blocking assignments so every
    // stage samples the previous stage's old value, independent of the order
    // the statements happen to be written in.
    always_ff @(posedge clk) begin
        prod_rr <= MW'(a_re) * MW'(w_re);
        prod_ii <= MW'(a_im) * MW'(w_im);
        prod_ri <= MW'(a_re) * MW'(w_im);
        prod_ir <= MW'(a_im) * MW'(w_re);
    end

    always_ff @(posedge clk) begin
        p_re <= PROD_W'(prod_rr) - PROD_W'(prod_ii);
        p_im <= PROD_W'(prod_ri) + PROD_W'(prod_ir);
    end

endmodule

// File: rtl/dbf_nch_beam.sv
// -----------------------------------------------------------------------------
// dbf_nch_beam
// N_CH-channel complex beamformer: per-channel complex weight multiply,
// pipelined adder tree, then a cut stage (right shift by SHIFT_BASE+cut_ctl
// with saturation to DW bits). Latency 3 + clog2(N_CH), full throughput.
// Weights are double-buffered; a commit swaps shadow->active on the first
// idle input cycle so a burst is never split across two weight sets.
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   din_i, din_q        N_CH packed signed samples, channel k at [k*DW +: DW]
//   din_valid           all channel samples valid this cycle
//   wr_en, wr_ch        shadow weight write strobe and channel index
//   wr_re, wr_im        shadow weight value (SHIFT_BASE fractional bits)
//   wt_commit           request shadow->active swap
//   wt_busy             swap requested but not applied yet
//   cut_ctl             extra right shift 0..7, travels with the sample
//   dout_i, dout_q      beam output, held while dout_valid is low
//   dout_valid          beam output valid
// Build option: define DBF_NCH_ROUND_EN for round-half-up in the cut stage;
// otherwise the cut truncates (floor).
// -----------------------------------------------------------------------------
module dbf_nch_beam
    import dbf_pkg::*;
#(
    parameter int N_CH       = 4,
    parameter int DW         = 16,
    parameter int WW         = 16,
    parameter int SHIFT_BASE = 13
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*DW-1:0]       din_i,
    input  logic [N_CH*DW-1:0]       din_q,
    input  logic                     din_valid,
    input  logic                     wr_en,
    input  logic [clog2(N_CH)-1:0]   wr_ch,
    input  logic [WW-1:0]            wr_re,
    input  logic [WW-1:0]            wr_im,
    input  logic                     wt_commit,
    output logic                     wt_busy,
    input  logic [2:0]               cut_ctl,
    output logic [DW-1:0]            dout_i,
    output logic [DW-1:0]            dout_q,
    output logic                     dout_valid
);

    localparam int LG     = clog2(N_CH);
    localparam int CHW    = LG;
    localparam int PROD_W = calc_pw(DW, WW);
    localparam int SUM_W  = calc_sw(DW, WW, N_CH);
    // Pipeline slots ahead of the cut register: 2 multiplier stages + LG tree levels.
    localparam int NS     = 2 + LG;

    localparam logic signed [WW-1:0]  W_ONE  = WW'(2 ** SHIFT_BASE);
    localparam logic signed [SUM_W:0] SAT_HI = (SUM_W + 1)'(sat_hi(DW));
    localparam logic signed [SUM_W:0] SAT_LO = (SUM_W + 1)'(sat_lo(DW));

    // -------------------------------------------------------------------------
    // Weight swap FSM
    // -------------------------------------------------------------------------
    wt_state_t state_q;
    wt_state_t state_d;
    logic      swap;

    // NOTE: every output of a combinational block gets a default before any
    // branch; a path that leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        case (state_q)
            ACTIVE: begin
                if (wt_commit) state_d = PENDING;
            end
            PENDING: begin
                // Only swap on an input gap so a burst sees one weight set.
                if (!din_valid) begin
                    swap    = 1'b1;
                    state_d = ACTIVE;
                end
            end
            default: state_d = ACTIVE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ACTIVE;
        else        state_q <= state_d;
    end

    assign wt_busy = (state_q == PENDING);

    // -------------------------------------------------------------------------
    // Weight bank (shadow + active)
    // -------------------------------------------------------------------------
    logic signed [WW-1:0] shd_re [N_CH];
    logic signed [WW-1:0] shd_im [N_CH];
    logic signed [WW-1:0] act_re [N_CH];
    logic signed [WW-1:0] act_im [N_CH];
    logic [N_CH-1:0]      wr_hit;

    always_comb begin
        wr_hit = '0;
        for (int k = 0; k < N_CH; k++) wr_hit[k] = wr_en && (wr_ch == CHW'(k));
    end

    // NOTE: the weight bank is a handful of flops with a defined power-up
    // value (unity beam), so it is reset; the wide datapath registers below
    // carry no reset because the valid pipeline already masks them.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int k = 0; k < N_CH; k++) begin
                shd_re[k] <= '0;
                shd_im[k] <= '0;
                act_re[k] <= W_ONE;
                act_im[k] <= '0;
            end
        end else begin
            for (int k = 0; k < N_CH; k++) begin
                if (wr_hit[k]) begin
                    shd_re[k] <= $signed(wr_re);
                    shd_im[k] <= $signed(wr_im);
                end
                // Write-first: a write landing on the swap cycle joins the copy.
                if (swap) begin
                    act_re[k] <= wr_hit[k] ? $signed(wr_re) : shd_re[k];
                    act_im[k] <= wr_hit[k] ? $signed(wr_im) : shd_im[k];
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Per-channel complex multipliers
    // -------------------------------------------------------------------------
    logic signed [PROD_W-1:0] prod_i [N_CH];
    logic signed [PROD_W-1:0] prod_q [N_CH];

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        dbf_cmult #(
            .DW (DW),
            .WW (WW)
        ) u_cmult (
            .clk  (clk),
            .a_re ($signed(din_i[k*DW +: DW])),
            .a_im ($signed(din_q[k*DW +: DW])),
            .w_re (act_re[k]),
            .w_im (act_im[k]),
            .p_re (prod_i[k]),
            .p_im (prod_q[k])
        );
    end

    // -------------------------------------------------------------------------
    // Valid and cut_ctl side pipelines
    // -------------------------------------------------------------------------
    logic [NS-1:0] vld_pipe;
    logic [2:0]    cut_pipe [NS];

    always_ff @(posedge clk) begin
        if (!rst_n) vld_pipe <= '0;
        else        vld_pipe <= {vld_pipe[NS-2:0], din_valid};
    end

    always_ff @(posedge clk) begin
        cut_pipe[0] <= cut_ctl;
        for (int s = 1; s < NS; s++) cut_pipe[s] <= cut_pipe[s-1];
    end

    // -------------------------------------------------------------------------
    // Adder tree: level 0 is the multiplier output, each further level is a
    // registered pairwise sum one bit wider than the level before.
    // -------------------------------------------------------------------------
    logic signed [SUM_W-1:0] sum_fin_i;
    logic signed [SUM_W-1:0] sum_fin_q;

    for (genvar l = 0; l <= LG; l++) begin : g_lvl
        localparam int NW = PROD_W + l;
        localparam int NN = N_CH >> l;

        logic signed [NW-1:0] sum_i [NN];
        logic signed [NW-1:0] sum_q [NN];

        if (l == 0) begin : g_leaf
            for (genvar n = 0; n < NN; n++) begin : g_node
                assign sum_i[n] = prod_i[n];
                assign sum_q[n] = prod_q[n];
            end
        end else begin : g_add
            for (genvar n = 0; n < NN; n++) begin : g_node
                always_ff @(posedge clk) begin
                    sum_i[n] <= NW'(g_lvl[l-1].sum_i[2*n]) + NW'(g_lvl[l-1].sum_i[2*n+1]);
                    sum_q[n] <= NW'(g_lvl[l-1].sum_q[2*n]) + NW'(g_lvl[l-1].sum_q[2*n+1]);
                end
            end
        end

        if (l == LG) begin : g_root
            assign sum_fin_i = sum_i[0];
            assign sum_fin_q = sum_q[0];
        end
    end

    // -------------------------------------------------------------------------
    // Cut stage: arithmetic shift by SHIFT_BASE+cut, then clamp to DW bits.
    // One guard bit keeps the optional rounding add from wrapping.
    // -------------------------------------------------------------------------
    function automatic logic signed [DW-1:0] cut_sat(input logic signed [SUM_W-1:0] sum,
                                                     input logic [2:0]              cut);
        int                    shamt;
        logic signed [SUM_W:0] ext;
        logic signed [SUM_W:0] shifted;
        shamt = SHIFT_BASE + int'(cut);
        ext   = {sum[SUM_W-1], sum};
`ifdef DBF_NCH_ROUND_EN
        if (shamt > 0) ext = ext + (SUM_W + 1)'(longint'(1) <<< (shamt - 1));
`endif
        shifted = ext >>> shamt;
        if (shifted > SAT_HI)      return SAT_HI[DW-1:0];
        else if (shifted < SAT_LO) return SAT_LO[DW-1:0];
        else                       return shifted[DW-1:0];
    endfunction

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_i     <= '0;
            dout_q     <= '0;
        end else begin
            dout_valid <= vld_pipe[NS-1];
            if (vld_pipe[NS-1]) begin
                dout_i <= cut_sat(sum_fin_i, cut_pipe[NS-1]);
                dout_q <= cut_sat(sum_fin_q, cut_pipe[NS-1]);
            end
        end
    end

endmodule

// File: tb/tb_dbf_nch_beam.sv
// -----------------------------------------------------------------------------
// tb_dbf_nch_beam
// Directed + randomized bench for dbf_nch_beam (N_CH=4, DW=WW=16, SHIFT_BASE=13).
// A behavioural model keeps the active/shadow weight sets and a pending flag,
// computes each beam sample with plain integer arithmetic when it enters,
// and queues it with the cycle it is due at the output.
// -----------------------------------------------------------------------------
module tb_dbf_nch_beam;
    import dbf_pkg::*;

    localparam int N_CH       = 4;
    localparam int DW         = 16;
    localparam int WW         = 16;
    localparam int SHIFT_BASE = 13;
    localparam int CHW        = clog2(N_CH);
    // A sample captured at edge c is visible after edge c+4: 5 cycles later.
    localparam int LAT_EDGES  = 4;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [N_CH*DW-1:0]     din_i;
    logic [N_CH*DW-1:0]     din_q;
    logic                   din_valid;
    logic                   wr_en;
    logic [CHW-1:0]         wr_ch;
    logic [WW-1:0]          wr_re;
    logic [WW-1:0]          wr_im;
    logic                   wt_commit;
    logic                   wt_busy;
    logic [2:0]             cut_ctl;
    logic signed [DW-1:0]   dout_i;
    logic signed [DW-1:0]   dout_q;
    logic                   dout_valid;

    dbf_nch_beam #(
        .N_CH       (N_CH),
        .DW         (DW),
        .WW         (WW),
        .SHIFT_BASE (SHIFT_BASE)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_i      (din_i),
        .din_q      (din_q),
        .din_valid  (din_valid),
        .wr_en      (wr_en),
        .wr_ch      (wr_ch),
        .wr_re      (wr_re),
        .wr_im      (wr_im),
        .wt_commit  (wt_commit),
        .wt_busy    (wt_busy),
        .cut_ctl    (cut_ctl),
        .dout_i     (dout_i),
        .dout_q     (dout_q),
        .dout_valid (dout_valid)
    );

    always #5 clk = ~clk;

    typedef struct {
        longint re;
        longint im;
        int     due;
    } exp_t;

    exp_t   sb[$];
    int     s_i [N_CH];
    int     s_q [N_CH];
    longint m_act_re [N_CH];
    longint m_act_im [N_CH];
    longint m_shd_re [N_CH];
    longint m_shd_im [N_CH];
    bit     m_pend;
    longint m_last_i;
    longint m_last_q;
    int     cyc    = 0;
    int     errors = 0;
    int     checks = 0;

    task automatic check(input string tag, input logic signed [63:0] obs,
                         input logic signed [63:0] want);
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed %0d, expected %0d (edge %0d)", tag, obs, want, cyc);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic model_reset();
        for (int k = 0; k < N_CH; k++) begin
            m_act_re[k] = 2 ** SHIFT_BASE;
            m_act_im[k] = 0;
            m_shd_re[k] = 0;
            m_shd_im[k] = 0;
        end
        m_pend   = 1'b0;
        m_last_i = 0;
        m_last_q = 0;
        sb.delete();
    endtask

    function automatic longint model_cut(input longint acc, input int cut);
        int     s;
        longint r;
        s = SHIFT_BASE + cut;
`ifdef DBF_NCH_ROUND_EN
        if (s > 0) acc = acc + (longint'(1) <<< (s - 1));
`endif
        r = acc >>> s;
        if (r > 2 ** (DW - 1) - 1) r = 2 ** (DW - 1) - 1;
        if (r < -(2 ** (DW - 1)))  r = -(2 ** (DW - 1));
        return r;
    endfunction

    function automatic exp_t model_sample(input int cut);
        longint ai;
        longint aq;
        exp_t   e;
        ai = 0;
        aq = 0;
        for (int k = 0; k < N_CH; k++) begin
            ai += longint'(s_i[k]) * m_act_re[k] - longint'(s_q[k]) * m_act_im[k];
            aq += longint'(s_i[k]) * m_act_im[k] + longint'(s_q[k]) * m_act_re[k];
        end
        e.re  = model_cut(ai, cut);
        e.im  = model_cut(aq, cut);
        e.due = cyc + LAT_EDGES;
        return e;
    endfunction

    // One clock: update the model with what the DUT samples at the edge,
    // then compare every output at the following falling edge.
    task automatic tick();
        bit   exp_v;
        exp_t e;
        @(posedge clk);
        cyc++;
        if (!rst_n) begin
            model_reset();
        end else begin
            if (din_valid) sb.push_back(model_sample(int'(cut_ctl)));
            if (wr_en) begin
                m_shd_re[wr_ch] = longint'($signed(wr_re));
                m_shd_im[wr_ch] = longint'($signed(wr_im));
            end
            if (m_pend) begin
                if (!din_valid) begin
                    for (int k = 0; k < N_CH; k++) begin
                        m_act_re[k] = m_shd_re[k];
                        m_act_im[k] = m_shd_im[k];
                    end
                    m_pend = 1'b0;
                end
            end else if (wt_commit) begin
                m_pend = 1'b1;
            end
        end
        @(negedge clk);
        exp_v = (sb.size() > 0) && (sb[0].due == cyc);
        check("dout_valid", dout_valid, exp_v);
        if (exp_v) begin
            e        = sb.pop_front();
            m_last_i = e.re;
            m_last_q = e.im;
        end
        check("dout_i", dout_i, m_last_i);
        check("dout_q", dout_q, m_last_q);
        check("wt_busy", wt_busy, m_pend);
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic int rand_dw();
        logic signed [DW-1:0] t;
        t = DW'($urandom);
        return int'(t);
    endfunction

    task automatic set_all(input int vi, input int vq);
        for (int k = 0; k < N_CH; k++) begin
            s_i[k] = vi;
            s_q[k] = vq;
        end
    endtask

    task automatic set_rand();
        for (int k = 0; k < N_CH; k++) begin
            s_i[k] = rand_dw();
            s_q[k] = rand_dw();
        end
    endtask

    task automatic drive(input bit v, input int cut);
        for (int k = 0; k < N_CH; k++) begin
            din_i[k*DW +: DW] = s_i[k][DW-1:0];
            din_q[k*DW +: DW] = s_q[k][DW-1:0];
        end
        din_valid = v;
        cut_ctl   = 3'(cut);
    endtask

    task automatic idle(input int n);
        din_valid = 1'b0;
        repeat (n) tick();
    endtask

    task automatic write_w(input int ch, input int re, input int im);
        din_valid = 1'b0;
        wr_en     = 1'b1;
        wr_ch     = CHW'(ch);
        wr_re     = WW'(re);
        wr_im     = WW'(im);
        tick();
        wr_en     = 1'b0;
    endtask

    task automatic commit_idle();
        din_valid = 1'b0;
        wt_commit = 1'b1;
        tick();
        wt_commit = 1'b0;
        tick();
        tick();
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rst_n     = 1'b0;
        din_valid = 1'b0;
        wr_en     = 1'b0;
        wr_ch     = '0;
        wr_re     = '0;
        wr_im     = '0;
        wt_commit = 1'b0;
        cut_ctl   = '0;
        set_all(0, 0);
        drive(1'b0, 0);
        model_reset();
        tick();
        tick();
        rst_n = 1'b1;
        idle(2);

        // Unity reset weights: 4 x 1000 -> 4000, then cut_ctl=2 -> 1000.
        set_all(1000, 0);
        drive(1'b1, 0); tick();
        idle(6);
        drive(1'b1, 2); tick();
        idle(6);

        // Saturation at both rails.
        set_all(30000, 0);
        drive(1'b1, 0); tick();
        set_all(-30000, 0);
        drive(1'b1, 0); tick();
        idle(6);

        // ch0 weight = j, others 0: (100 + 200j) * j = -200 + 100j.
        write_w(0, 0, 8192);
        for (int k = 1; k < N_CH; k++) write_w(k, 0, 0);
        commit_idle();
        set_rand();
        s_i[0] = 100;
        s_q[0] = 200;
        drive(1'b1, 0); tick();
        idle(6);

        // Commit inside a 20-sample burst: swap waits for the first gap, and a
        // write landing on the swap cycle is part of the new set.
        for (int k = 0; k < N_CH; k++) write_w(k, rand_dw(), rand_dw());
        for (int b = 0; b < 20; b++) begin
            set_rand();
            drive(1'b1, int'($urandom_range(0, 2)));
            wt_commit = (b == 3);
            tick();
        end
        wt_commit = 1'b0;
        din_valid = 1'b0;
        wr_en     = 1'b1;
        wr_ch     = CHW'(2);
        wr_re     = WW'(rand_dw());
        wr_im     = WW'(rand_dw());
        tick();
        wr_en     = 1'b0;
        for (int b = 0; b < 10; b++) begin
            set_rand();
            drive(1'b1, int'($urandom_range(0, 2)));
            tick();
        end
        idle(6);

        // Rounding corner: ch0 unity, cut_ctl=1, inputs +3 then -3.
        write_w(0, 8192, 0);
        for (int k = 1; k < N_CH; k++) write_w(k, 0, 0);
        commit_idle();
        set_all(0, 0);
        s_i[0] = 3;
        drive(1'b1, 1); tick();
        s_i[0] = -3;
        drive(1'b1, 1); tick();
        idle(6);

        // Random soak: mixed valid gaps, writes, commits and cut values.
        for (int n = 0; n < 300; n++) begin
            set_rand();
            drive(($urandom % 4) != 0, int'($urandom_range(0, 7)));
            wr_en     = (($urandom % 4) == 0);
            wr_ch     = CHW'($urandom);
            wr_re     = WW'($urandom);
            wr_im     = WW'($urandom);
            wt_commit = (($urandom % 16) == 0);
            tick();
        end
        wr_en     = 1'b0;
        wt_commit = 1'b0;
        idle(6);

        // Reset mid-burst with a swap pending: in-flight samples vanish,
        // weights return to unity and wt_busy clears.
        for (int k = 0; k < N_CH; k++) write_w(k, rand_dw(), rand_dw());
        for (int b = 0; b < 8; b++) begin
            set_rand();
            drive(1'b1, 0);
            wt_commit = (b == 1);
            tick();
        end
        wt_commit = 1'b0;
        rst_n     = 1'b0;
        set_rand();
        drive(1'b1, 0);
        tick();
        rst_n = 1'b1;
        for (int b = 0; b < 6; b++) begin
            set_all(rand_dw() / 4, rand_dw() / 4);
            drive(1'b1, 0);
            tick();
        end
        idle(6);

        // Everything queued must have come out within a bounded window.
        for (int i = 0; i < 20 && sb.size() > 0; i++) tick();
        check("drain_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dbf_nch_beam.md
Name: dbf_nch_beam

Overview:
- Parametrised successor to the single-channel elevation DBF cell with cut stage.
- Takes N_CH parallel complex channel samples and multiplies each by its own complex weight from a double-buffered weight bank.
- Sums the products in a pipelined adder tree, then applies a cut_ctl-selected shift with saturation to a DW-bit complex beam output.
- Sits between the channel DDC outputs and the beam processing chain, one instance per formed beam.

Parameters:
- N_CH, 4, number of channels; power of two, 2..16.
- DW, 16, input/output I/Q width, signed.
- WW, 16, weight real/imag width, signed fixed-point with SHIFT_BASE fractional bits.
- SHIFT_BASE, 13, right shift applied when cut_ctl=0; weight 1.0 = 2^SHIFT_BASE.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  synchronous, active-low reset.
- din_i  in  N_CH*DW  channel I samples; channel k occupies bits [k*DW +: DW].
- din_q  in  N_CH*DW  channel Q samples; same packing as din_i.
- din_valid  in  1  all channel samples valid this cycle.
- wr_en  in  1  write one shadow weight.
- wr_ch  in  clog2(N_CH)  channel index of the shadow write.
- wr_re  in  WW  weight real part.
- wr_im  in  WW  weight imaginary part.
- wt_commit  in  1  pulse: request shadow-to-active swap.
- wt_busy  out  1  swap requested but not yet applied.
- cut_ctl  in  3  extra right shift 0..7; registered with the data at pipeline entry.
- dout_i  out  DW  beam I.
- dout_q  out  DW  beam Q.
- dout_valid  out  1  beam sample valid.

Behaviour:
- Reset:
  - Active weights = (2^SHIFT_BASE, 0) for every channel, i.e. unity sum.
  - Shadow weights = 0.
  - dout_i, dout_q, dout_valid, wt_busy = 0; all pipeline valid bits cleared.
  - Reset mid-stream discards all in-flight samples.
- Complex multiply per channel, 2 registered stages:
  - stage 1 registers the four products.
  - stage 2 registers P_I = dI*wr - dQ*wi and P_Q = dI*wi + dQ*wr.
  - Product width PW = DW+WW+1; no overflow is possible.
- Adder tree: clog2(N_CH) registered levels of pairwise sums, width growing by 1 bit per level; final width SW = PW+clog2(N_CH).
- Cut stage, 1 register:
  - s = SHIFT_BASE + cut_ctl.
  - Output = sat_DW(sum >>> s), arithmetic shift.
  - Saturation limits are +2^(DW-1)-1 and -2^(DW-1).
- Latency: L = 3 + clog2(N_CH) cycles from din_valid to dout_valid; 5 for N_CH=4.
  - Full throughput, one sample per cycle; no backpressure.
  - dout_i/dout_q hold their last value while dout_valid=0.
- Weight FSM, two states:
  - ACTIVE: wt_commit moves to PENDING.
  - PENDING (wt_busy=1): on the first cycle with din_valid=0, copy shadow->active and return to ACTIVE. This guarantees a burst is never split across weight sets.
  - Samples entering the pipeline on the swap cycle or later use the new weights.
  - The swap copy is a single-cycle parallel load.
- Shadow writes are accepted in any state.
  - A write in the same cycle as the swap is included in the copy (write-first).
  - A wr_en and wt_commit in the same cycle: the write lands before the swap.
  - wt_commit while already PENDING has no additional effect.
- din_valid held high indefinitely keeps the block PENDING; the weights stay old and no error is raised.

Optional Feature:
- Macro: DBF_NCH_ROUND_EN.
- Defined: round half up in the cut stage; add 2^(s-1) before the shift, with saturation applied after the add.
- Undefined: plain truncation, i.e. floor via arithmetic shift.
- Latency is identical in both builds.

Decomposition:
- Package dbf_pkg holds:
  - the clog2 function;
  - derived width constants PW and SW;
  - the cut saturation limits;
  - the weight FSM state enumeration {ACTIVE, PENDING}.
- Sub-module dbf_cmult: 2-stage signed complex multiplier, instantiated N_CH times by a generate loop.
- Adder tree, weight bank, FSM and cut stage live in the top module.

Test Plan:
- Unity reset weights, N_CH=4, all channels I=1000, Q=0, cut_ctl=0 -> dout_i=4000, dout_q=0, dout_valid exactly 5 cycles after din_valid.
- Same stimulus, cut_ctl=2 -> dout_i=1000; then all channels I=30000, cut_ctl=0 -> dout_i=32767 (saturated); I=-30000 -> dout_i=-32768.
- Load ch0=(0,8192) (value j), ch1..3=(0,0), commit during idle; input ch0=(100,200) -> dout_i=-200, dout_q=100.
- Commit while din_valid is high for a 20-sample burst:
  - wt_busy=1 throughout the burst, and all 20 outputs use the old weights;
  - the swap happens on the first idle cycle, and the next burst uses the new weights;
  - a wr_en issued on the swap cycle is included in the new set.
- ch0 unity, others 0, cut_ctl=1, input I=3 then I=-3:
  - with DBF_NCH_ROUND_EN: outputs 2 then -1;
  - without it: outputs 1 then -2.
- Assert rst_n=0 for one cycle mid-burst with PENDING set -> dout_valid=0 from the next cycle, no stale outputs emerge, wt_busy=0, and weights return to unity.
